// File: rtl/alu_muldiv_if.sv
// Request/response bundle for the multi-cycle multiply/divide unit.
// The master side issues operations; the slave side is the unit itself.
interface alu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, flush, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, flush, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/alu_muldiv.sv
// RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide, fixed latency.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_muldiv_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_zero, div_ovf;
    logic [WIDTH:0]     mul_sum;
    logic [ACC_W-1:0]   mul_next;
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_ge;
    logic [ACC_W-1:0]   div_next;
    logic [ACC_W-1:0]   step_acc;
    logic [ACC_W-1:0]   prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fin_res;

    // Operand decode at accept: signedness per funct3, magnitudes and bypass cases
    always_comb begin
        a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                   (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        a_neg    = a_signed && bus.a[WIDTH-1];
        b_neg    = b_signed && bus.b[WIDTH-1];
        a_mag    = a_neg ? -bus.a : bus.a;
        b_mag    = b_neg ? -bus.b : bus.b;
        div_zero = (bus.b == '0);
        div_ovf  = !bus.op[0] && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [ACC_W-1:0] fast_a, fast_b, fast_prod;

    // Sign-extended operands; the low 2*WIDTH product bits are exact for every mode
    always_comb begin
        fast_a    = {{WIDTH{a_signed && bus.a[WIDTH-1]}}, bus.a};
        fast_b    = {{WIDTH{b_signed && bus.b[WIDTH-1]}}, bus.b};
        fast_prod = fast_a * fast_b;
    end
`endif

    // One iteration of either datapath, plus the sign-corrected final result
    always_comb begin
        mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        div_sh   = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        div_ge   = (div_sh >= {1'b0, opnd_q});
        div_next = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                          : {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};

        step_acc = op_q[2] ? div_next : mul_next;

        prod = neg_q ? -step_acc : step_acc;
        quo  = step_acc[WIDTH-1:0];
        rem  = step_acc[ACC_W-1:WIDTH];
        if (!op_q[2]) begin
            fin_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[ACC_W-1:WIDTH];
        end else if (op_q[1]) begin
            fin_res = rneg_q ? -rem : rem;
        end else begin
            fin_res = neg_q ? -quo : quo;
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        unique case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (bus.start && !bus.flush) begin
                    op_d   = bus.op;
                    cnt_d  = '0;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (bus.op[2]) begin
                        if (div_zero) begin
                            result_d = bus.op[1] ? bus.a : '1;
                            state_d  = FIN;
                        end else if (div_ovf) begin
                            result_d = bus.op[1] ? '0 : bus.a;
                            state_d  = FIN;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            opnd_d  = b_mag;
                            state_d = CALC;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        result_d = (bus.op[1:0] == 2'b00) ? fast_prod[WIDTH-1:0]
                                                          : fast_prod[ACC_W-1:WIDTH];
                        state_d  = FIN;
`else
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        state_d = CALC;
`endif
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = fin_res;
                        state_d  = FIN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed and randomized checks of alu_muldiv against a plain-arithmetic RV32M model.
module tb_alu_muldiv;
    localparam int unsigned W = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_muldiv_if #(.WIDTH(W)) bus ();
    alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_result = '0;

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r  = 0;
        p  = '0;
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return a;
                r = sa / sb;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                r = ua / ub;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                r = sa % sb;
            end
            default: begin
                if (b == 0) return a;
                r = ua % ub;
            end
        endcase
        return 32'(r);
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return W + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a start for one accept edge, then scramble operands (DUT must have latched them)
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Wait for done (bounded); optionally re-pulse start at cycle poke_at while busy
    task automatic finish_op(input string tag, input logic [31:0] exp, input int lat, input int poke_at);
        int cyc;
        int busy_n;
        cyc = 1;
        busy_n = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy === 1'b1) busy_n++;
            if (cyc == poke_at) bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_res"}, bus.result, exp);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat - 1));
        last_result = exp;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dir[10];
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int done_seen;

    initial begin
        dir[0] = '{3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB};
        dir[1] = '{3'd1, MIN,          32'hFFFF_FFFF, 32'h0000_0000};
        dir[2] = '{3'd2, MIN,          32'hFFFF_FFFF, 32'h8000_0000};
        dir[3] = '{3'd3, MIN,          32'hFFFF_FFFF, 32'h7FFF_FFFF};
        dir[4] = '{3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD};
        dir[5] = '{3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF};
        dir[6] = '{3'd5, 32'd100,      32'd7,         32'd14};
        dir[7] = '{3'd7, 32'd100,      32'd7,         32'd2};
        dir[8] = '{3'd5, 32'd5,        32'd0,         32'hFFFF_FFFF};
        dir[9] = '{3'd6, MIN,          32'hFFFF_FFFF, 32'h0000_0000};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        @(posedge clk); #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, issued back-to-back (each start lands in the previous FIN cycle)
        foreach (dir[i]) begin
            launch(dir[i].op, dir[i].a, dir[i].b);
            finish_op($sformatf("dir%0d", i), dir[i].exp, ref_lat(dir[i].op, dir[i].a, dir[i].b), 0);
        end

        // Start while busy is ignored; operands are not relatched
        launch(3'd4, 32'd1000, 32'd7);
        finish_op("poke_div", 32'd142, W + 1, 10);

        // Flush and start together in the FIN cycle: flush wins
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", 32'(bus.busy), 32'd0);
        check("flush_start_done", 32'(bus.done), 32'd0);

        // Flush at cycle 20 of a divide
        launch(3'd5, 32'hDEAD_BEEF, 32'd3);
        done_seen = 0;
        for (int c = 1; c < 20; c++) begin
            if (bus.done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        check("flush_busy_c20", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy_c21", 32'(bus.busy), 32'd0);
        check("flush_done_c21", 32'(bus.done), 32'd0);
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        check("flush_no_done", 32'(done_seen), 32'd0);
        check("flush_result_kept", bus.result, last_result);

        // Asynchronous reset mid-CALC
        launch(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) begin @(posedge clk); #1; end
        check("prerst_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_result", bus.result, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        launch(3'd7, 32'd1001, 32'd10);
        finish_op("post_rst", 32'd1, ref_lat(3'd7, 32'd1001, 32'd10), 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = MIN; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            launch(rop, ra, rb);
            finish_op($sformatf("rand%0d_op%0d", i, rop), ref_res(rop, ra, rb), ref_lat(rop, ra, rb), 0);
        end

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
